hw_accel_morph_chain: RTL and testbench



---
 rtl/hw_accel_pkg.sv | 33 +++
 rtl/hw_accel_morph_stage.sv | 124 ++++++++++++
 rtl/hw_accel_morph_chain.sv | 150 +++++++++++++++
 tb/tb_hw_accel_morph_chain.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hw_accel_pkg.sv
// Shared types for the binary morphology chain: op encodings, FSM states and the beat record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hw_accel_pkg;

  localparam logic [1:0] OP_BYPASS = 2'd0;
  localparam logic [1:0] OP_DILATE = 2'd1;
  localparam logic [1:0] OP_ERODE  = 2'd2;   // 2'd3 also decodes as erode

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  // One beat travelling between stages; pix is the binary pixel value.
  typedef struct packed {
    logic valid;
    logic flush;
    logic pix;
  } beat_t;

  localparam int DEF_IMG_WIDTH    = 512;
  localparam int DEF_IMG_HEIGHT   = 512;
  localparam int DEF_NUM_STAGES   = 2;
  localparam int DEF_FRAME_PIXELS = DEF_IMG_WIDTH * DEF_IMG_HEIGHT;
  localparam int DEF_FLUSH_LEN    = DEF_NUM_STAGES * (DEF_IMG_WIDTH + 1);

  function automatic int frame_pixels(input int w, input int h);
    return w * h;
  endfunction

  function automatic int flush_len(input int n, input int w);
    return n * (w + 1);
  endfunction

endpackage

// File: rtl/hw_accel_morph_stage.sv
// One 3x3 binary morphology stage (bypass / dilate / erode) with two line buffers.
// Latency: output for centre (r,c) registered 1 clk after the beat carrying (r+1,c+1).
// Backpressure: none; purely beat-driven, advances only on beat_in.valid.
// Ports: clk, rst (async, active-high), cfg_op (op sampled at frame start),
//        beat_in (upstream beat), beat_out (registered result beat).
module hw_accel_morph_stage
  import hw_accel_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int NUM_STAGES = DEF_NUM_STAGES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] cfg_op,
  input  beat_t      beat_in,
  output beat_t      beat_out
);

  localparam int COL_W  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  // Flush beats keep advancing the row counter a few rows past the image.
  localparam int ROW_W  = $clog2(IMG_HEIGHT + NUM_STAGES + 3);
  localparam int SR_LEN = 2 * IMG_WIDTH + 2;

  logic [COL_W-1:0]  col_q, col_eff, c_col;
  logic [ROW_W-1:0]  row_q, row_eff, c_row;
  logic              seen_flush_q;
  logic [1:0]        op_q;
  // Two line buffers plus the window columns, kept as one delay line:
  // sr_q[j] holds the beat that arrived j+1 beats ago.
  logic [SR_LEN-1:0] sr_q;
  beat_t             out_q;

  logic       frame_start, emit, is_real, top_ok, bot_ok, left_ok, right_ok;
  logic       border, res;
  logic [8:0] taps, tm;

  always_comb begin
    // A real beat after flush beats (or the first after reset) starts a frame.
    frame_start = beat_in.valid && !beat_in.flush &&
                  (seen_flush_q || (col_q == '0 && row_q == '0));
    col_eff = frame_start ? '0 : col_q;
    row_eff = frame_start ? '0 : row_q;

    // Centre lags the incoming beat by IMG_WIDTH+1 positions.
    if (col_eff != '0) begin
      c_col = col_eff - COL_W'(1);
      c_row = row_eff - ROW_W'(1);
    end else begin
      c_col = COL_W'(IMG_WIDTH - 1);
      c_row = row_eff - ROW_W'(2);
    end
    emit    = (row_eff >= ROW_W'(2)) || (row_eff == ROW_W'(1) && col_eff != '0);
    is_real = c_row < ROW_W'(IMG_HEIGHT);

    top_ok   = c_row != '0;
    bot_ok   = c_row != ROW_W'(IMG_HEIGHT - 1);
    left_ok  = c_col != '0;
    right_ok = c_col != COL_W'(IMG_WIDTH - 1);

    // Row-major taps, index 0 = top-left, 4 = centre, 8 = bottom-right.
    taps[0] = sr_q[2*IMG_WIDTH+1];
    taps[1] = sr_q[2*IMG_WIDTH];
    taps[2] = sr_q[2*IMG_WIDTH-1];
    taps[3] = sr_q[IMG_WIDTH+1];
    taps[4] = sr_q[IMG_WIDTH];
    taps[5] = sr_q[IMG_WIDTH-1];
    taps[6] = sr_q[1];
    taps[7] = sr_q[0];
    taps[8] = beat_in.pix;

    // Outside neighbours are neutral: 0 for OR (dilate), 1 for AND (erode).
    border = (op_q != OP_DILATE);
    tm     = '0;
    for (int i = 0; i < 9; i++) begin
      if ((i / 3 != 0 || top_ok) && (i / 3 != 2 || bot_ok) &&
          (i % 3 != 0 || left_ok) && (i % 3 != 2 || right_ok))
        tm[i] = taps[i];
      else
        tm[i] = border;
    end

    case (op_q)
      OP_BYPASS: res = taps[4];
      OP_DILATE: res = |tm;
      default:   res = &tm;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      seen_flush_q <= 1'b0;
      op_q         <= OP_BYPASS;
      out_q        <= '0;
    end else begin
      out_q.valid <= beat_in.valid && emit;
      out_q.flush <= !is_real;
      out_q.pix   <= is_real && res;
      if (beat_in.valid) begin
        seen_flush_q <= beat_in.flush;
        if (frame_start)
          op_q <= cfg_op;
        if (col_eff == COL_W'(IMG_WIDTH - 1)) begin
          col_q <= '0;
          row_q <= row_eff + ROW_W'(1);
        end else begin
          col_q <= col_eff + COL_W'(1);
          row_q <= row_eff;
        end
      end
    end
  end

  // Pixel history needs no reset: stale taps are always masked by the border logic.
  always_ff @(posedge clk) begin
    if (beat_in.valid)
      sr_q <= {sr_q[SR_LEN-2:0], beat_in.pix};
  end

  assign beat_out = out_q;

endmodule

// File: rtl/hw_accel_morph_chain.sv
// Cascade of NUM_STAGES 3x3 binary morphology stages with per-frame config shadowing.
// Latency: centre (r,c) appears NUM_STAGES*(IMG_WIDTH+2)+1 beats/clks after pixel (r,c) enters.
// Backpressure: pixel_in_ready drops for NUM_STAGES*(IMG_WIDTH+1) clks of self-flush per frame.
// Ports: clk, rst (async, active-high), cfg_stage_op (2 bits per stage), pixel_in/_valid/_ready,
//        pixel_out/_valid, frame_done (pulse), busy; fg_count when HW_ACCEL_MORPH_STATS_EN.
// Optional: define HW_ACCEL_MORPH_STATS_EN for the per-frame foreground count output.
module hw_accel_morph_chain
  import hw_accel_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int NUM_STAGES = DEF_NUM_STAGES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2*NUM_STAGES-1:0] cfg_stage_op,
  input  logic [DATA_WIDTH-1:0]   pixel_in,
  input  logic                    pixel_in_valid,
  output logic                    pixel_in_ready,
  output logic [DATA_WIDTH-1:0]   pixel_out,
  output logic                    pixel_out_valid,
  output logic                    frame_done,
  output logic                    busy
`ifdef HW_ACCEL_MORPH_STATS_EN
  ,
  output logic [$clog2(IMG_WIDTH*IMG_HEIGHT+1)-1:0] fg_count
`endif
);

  localparam int FRAME_PIX = frame_pixels(IMG_WIDTH, IMG_HEIGHT);
  localparam int FLUSH_LEN = flush_len(NUM_STAGES, IMG_WIDTH);
  localparam int CNT_W     = $clog2(FRAME_PIX + 1);
  localparam int FL_W      = $clog2(FLUSH_LEN + 1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        in_cnt_q, out_cnt_q;
  logic [FL_W-1:0]         fl_cnt_q;
  logic [2*NUM_STAGES-1:0] shadow_q, cfg_live;
  logic                    accept;
  beat_t                   head, last;
  beat_t                   chain [NUM_STAGES+1];

  assign accept = pixel_in_valid && pixel_in_ready;

  always_comb begin
    state_d        = state_q;
    pixel_in_ready = 1'b1;
    busy           = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (accept)
          state_d = RUN;
      end
      RUN: begin
        if (accept && in_cnt_q == CNT_W'(FRAME_PIX - 1))
          state_d = FLUSH;
      end
      FLUSH: begin
        pixel_in_ready = 1'b0;
        if (fl_cnt_q == FL_W'(FLUSH_LEN - 1))
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      in_cnt_q <= '0;
      fl_cnt_q <= '0;
      shadow_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == FLUSH)
        in_cnt_q <= '0;
      else if (accept)
        in_cnt_q <= in_cnt_q + CNT_W'(1);
      fl_cnt_q <= (state_q == FLUSH) ? fl_cnt_q + FL_W'(1) : '0;
      if (state_q == IDLE && accept)
        shadow_q <= cfg_stage_op;
    end
  end

  // Each stage samples its op on its own first real beat. Stage 0 starts while
  // still in IDLE, so it sees the live value the shadow is capturing that cycle;
  // later stages start once the shadow already holds this frame's config.
  assign cfg_live = (state_q == IDLE) ? cfg_stage_op : shadow_q;

  always_comb begin
    head.valid = (state_q == FLUSH) || accept;
    head.flush = (state_q == FLUSH);
    head.pix   = (state_q != FLUSH) && (pixel_in != '0);
  end

  assign chain[0] = head;

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
    hw_accel_morph_stage #(
      .IMG_WIDTH (IMG_WIDTH),
      .IMG_HEIGHT(IMG_HEIGHT),
      .NUM_STAGES(NUM_STAGES)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .cfg_op  (cfg_live[2*g +: 2]),
      .beat_in (chain[g]),
      .beat_out(chain[g+1])
    );
  end

  assign last = chain[NUM_STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_out_valid <= 1'b0;
      pixel_out       <= '0;
      frame_done      <= 1'b0;
      out_cnt_q       <= '0;
    end else begin
      pixel_out_valid <= last.valid && !last.flush;
      pixel_out       <= {DATA_WIDTH{last.valid && !last.flush && last.pix}};
      frame_done      <= pixel_out_valid && (out_cnt_q == CNT_W'(FRAME_PIX - 1));
      if (pixel_out_valid)
        out_cnt_q <= (out_cnt_q == CNT_W'(FRAME_PIX - 1)) ? '0 : out_cnt_q + CNT_W'(1);
    end
  end

`ifdef HW_ACCEL_MORPH_STATS_EN
  logic [CNT_W-1:0] fg_run_q;

  // Running count restarts with each frame; the total lands together with frame_done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fg_run_q <= '0;
      fg_count <= '0;
    end else if (pixel_out_valid) begin
      if (out_cnt_q == CNT_W'(FRAME_PIX - 1)) begin
        fg_count <= fg_run_q + CNT_W'(pixel_out[0]);
        fg_run_q <= '0;
      end else begin
        fg_run_q <= fg_run_q + CNT_W'(pixel_out[0]);
      end
    end
  end
`endif

endmodule

// File: tb/tb_hw_accel_morph_chain.sv
module tb_hw_accel_morph_chain;

  localparam int W    = 8;
  localparam int H    = 8;
  localparam int N    = 2;
  localparam int DW   = 8;
  localparam int NPIX = W * H;
  localparam int FLEN = N * (W + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic [2*N-1:0]  cfg_stage_op;
  logic [DW-1:0]   pixel_in;
  logic            pixel_in_valid;
  logic            pixel_in_ready;
  logic [DW-1:0]   pixel_out;
  logic            pixel_out_valid;
  logic            frame_done;
  logic            busy;
`ifdef HW_ACCEL_MORPH_STATS_EN
  logic [$clog2(NPIX+1)-1:0] fg_count;
`endif

  hw_accel_morph_chain #(
    .DATA_WIDTH(DW),
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .NUM_STAGES(N)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_stage_op   (cfg_stage_op),
    .pixel_in       (pixel_in),
    .pixel_in_valid (pixel_in_valid),
    .pixel_in_ready (pixel_in_ready),
    .pixel_out      (pixel_out),
    .pixel_out_valid(pixel_out_valid),
    .frame_done     (frame_done),
    .busy           (busy)
`ifdef HW_ACCEL_MORPH_STATS_EN
    ,
    .fg_count       (fg_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         pat;
    logic [3:0] cfg;
    logic [3:0] cfg_mid;
    int         mid_at;
    bit         gaps;
    int         exp_fg;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  logic [DW-1:0] sb_q[$];
  int            fgexp_q[$];
  logic [DW-1:0] cap[$];
  logic [DW-1:0] cap_ref[$];
  int            out_in_frame = 0;
  int            fg_obs = 0;
  int            frames_done = 0;
  int            last_fg = 0;
  bit            done_exp = 0;

  logic          img [NPIX];
  logic          rimg[NPIX];
  logic          expd[NPIX];
  logic [DW-1:0] pv  [NPIX];

  // Output scoreboard, sampled away from the active edge.
  always @(negedge clk) begin : mon
    int e;
    if (rst) begin
      out_in_frame = 0;
      fg_obs       = 0;
      done_exp     = 0;
    end else begin
      if (done_exp) begin
        check("frame_done_pulse", frame_done, 1);
        done_exp = 0;
        frames_done++;
        if (fgexp_q.size() > 0) begin
          e = fgexp_q.pop_front();
          check("frame_fg_vs_model", last_fg, e);
`ifdef HW_ACCEL_MORPH_STATS_EN
          check("fg_count", fg_count, e);
`endif
        end
      end else if (frame_done) begin
        check("frame_done_spurious", frame_done, 0);
      end
      if (pixel_out_valid) begin
        cap.push_back(pixel_out);
        if (sb_q.size() == 0)
          check("unexpected_output", pixel_out_valid, 0);
        else
          check($sformatf("pixel[%0d]", out_in_frame), pixel_out, sb_q.pop_front());
        out_in_frame++;
        if (pixel_out != '0)
          fg_obs++;
        if (out_in_frame == NPIX) begin
          done_exp     = 1;
          last_fg      = fg_obs;
          out_in_frame = 0;
          fg_obs       = 0;
        end
      end
    end
  end

  // Frame-level reference: explicit 2-D neighbourhood with neutral borders.
  task automatic compute_model(input logic [3:0] cfg, output int fg);
    logic       cur[NPIX];
    logic       nxt[NPIX];
    logic [1:0] op;
    logic       acc, v;
    int         rr, cc;
    cur = img;
    for (int s = 0; s < N; s++) begin
      op = cfg[2*s +: 2];
      for (int r = 0; r < H; r++) begin
        for (int c = 0; c < W; c++) begin
          if (op == 2'd0) begin
            nxt[r*W+c] = cur[r*W+c];
          end else begin
            acc = (op != 2'd1);
            for (int dr = -1; dr <= 1; dr++) begin
              for (int dc = -1; dc <= 1; dc++) begin
                rr = r + dr;
                cc = c + dc;
                if (rr >= 0 && rr < H && cc >= 0 && cc < W) v = cur[rr*W+cc];
                else v = (op != 2'd1);
                acc = (op == 2'd1) ? (acc | v) : (acc & v);
              end
            end
            nxt[r*W+c] = acc;
          end
        end
      end
      cur = nxt;
    end
    fg = 0;
    for (int i = 0; i < NPIX; i++) begin
      expd[i] = cur[i];
      fg += int'(cur[i]);
    end
  endtask

  task automatic load_img(input int pat);
    for (int i = 0; i < NPIX; i++) begin
      case (pat)
        0:       img[i] = (i == 4*W + 4);
        1:       img[i] = 1'b1;
        2:       img[i] = (i == 2*W + 5);
        3:       img[i] = (i % 3 == 0) && (i < 51);
        default: img[i] = rimg[i];
      endcase
      pv[i] = img[i] ? DW'($urandom_range(1, 255)) : '0;
    end
  endtask

  task automatic send(input logic [DW-1:0] v);
    logic r;
    int   t;
    pixel_in       = v;
    pixel_in_valid = 1'b1;
    t = 0;
    forever begin
      r = pixel_in_ready;
      @(posedge clk);
      #1;
      if (r) break;
      t++;
      if (t > 2000) begin
        check("send_timeout", t, 0);
        break;
      end
    end
  endtask

  task automatic push_expected(input logic [3:0] cfg);
    int fg;
    compute_model(cfg, fg);
    for (int i = 0; i < NPIX; i++)
      sb_q.push_back(expd[i] ? {DW{1'b1}} : '0);
    fgexp_q.push_back(fg);
  endtask

  task automatic run_frame(input vec_t v);
    int lowc, t, fd0;
    load_img(v.pat);
    push_expected(v.cfg);
    cap.delete();
    fd0 = frames_done;
    cfg_stage_op = v.cfg;
    for (int i = 0; i < NPIX; i++) begin
      if (i == v.mid_at) cfg_stage_op = v.cfg_mid;
      if (v.gaps && $urandom_range(0, 1) == 1) begin
        pixel_in_valid = 1'b0;
        pixel_in       = 8'hAA;
        @(posedge clk);
        #1;
      end
      send(pv[i]);
      if (i == 0) check({v.name, "_busy"}, busy, 1);
    end
    pixel_in_valid = 1'b0;
    lowc = 0;
    while (!pixel_in_ready && lowc < 1000) begin
      lowc++;
      @(posedge clk);
      #1;
    end
    check({v.name, "_ready_low_cycles"}, lowc, FLEN);
    t = 0;
    while (frames_done == fd0 && t < 1000) begin
      t++;
      @(posedge clk);
      #1;
    end
    check({v.name, "_frame_done_count"}, frames_done - fd0, 1);
    if (v.exp_fg >= 0) check({v.name, "_fg"}, last_fg, v.exp_fg);
    check({v.name, "_sb_drained"}, sb_q.size(), 0);
  endtask

  function automatic vec_t mk(input string nm, input int pat, input logic [3:0] cfg,
                              input logic [3:0] cfg_mid, input int mid_at,
                              input bit gaps, input int exp_fg);
    vec_t v;
    v.name = nm; v.pat = pat; v.cfg = cfg; v.cfg_mid = cfg_mid;
    v.mid_at = mid_at; v.gaps = gaps; v.exp_fg = exp_fg;
    return v;
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t vt[8];
    int   d;
    // cfg bits [1:0] = stage 0, [3:2] = stage 1; 1 dilate, 2 erode, 0 bypass.
    vt[0] = mk("dilate_single",  0, 4'b0001, 4'b0001, -1, 1'b0, 9);
    vt[1] = mk("erode_dil_ones", 1, 4'b0110, 4'b0110, -1, 1'b0, 64);
    vt[2] = mk("erode_dil_iso",  2, 4'b0110, 4'b0110, -1, 1'b0, 0);
    vt[3] = mk("mid_cfg_change", 0, 4'b0000, 4'b0101, 30, 1'b0, 1);
    vt[4] = mk("next_frame_dil", 0, 4'b0101, 4'b0101, -1, 1'b0, 25);
    vt[5] = mk("bypass_17",      3, 4'b0000, 4'b0000, -1, 1'b0, 17);
    vt[6] = mk("rand_cont",      4, 4'b1001, 4'b1001, -1, 1'b0, -1);
    vt[7] = mk("rand_gaps",      4, 4'b1001, 4'b1001, -1, 1'b1, -1);

    for (int i = 0; i < NPIX; i++) rimg[i] = ($urandom_range(0, 9) < 4);

    rst            = 1'b1;
    cfg_stage_op   = '0;
    pixel_in       = '0;
    pixel_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", pixel_in_ready, 1);
    check("rst_out", pixel_out, 0);
    check("rst_out_valid", pixel_out_valid, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      run_frame(vt[i]);
      if (i == 6) cap_ref = cap;
      if (i == 7) begin
        check("gap_vs_cont_len", cap.size(), cap_ref.size());
        d = 0;
        for (int k = 0; k < cap.size() && k < cap_ref.size(); k++)
          if (cap[k] !== cap_ref[k]) d++;
        check("gap_vs_cont_diff", d, 0);
      end
    end

    // Reset in the middle of a frame, then a clean frame.
    load_img(1);
    push_expected(4'b0110);
    cfg_stage_op = 4'b0110;
    for (int i = 0; i < 20; i++) send(pv[i]);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", pixel_out_valid, 0);
    check("midrst_out", pixel_out, 0);
    check("midrst_frame_done", frame_done, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", pixel_in_ready, 1);
    pixel_in_valid = 1'b0;
    sb_q.delete();
    fgexp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    cap.delete();
    repeat (40) @(posedge clk);
    #1;
    check("post_rst_silent", cap.size(), 0);
    run_frame(mk("after_reset", 0, 4'b0001, 4'b0001, -1, 1'b0, 9));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
